// File: rtl/fir_sample_loader_pkg.sv
// Shared constants and state encoding for the FIR sample loader.
// The loader writes one frame of samples into FIR sample memory and then starts the filter.
package fir_sample_loader_pkg;

    localparam int LDR_SAMPLE_W     = 8;
    localparam int LDR_ADDR_W       = 10;
    localparam int LDR_DEPTH        = 1024;
    localparam int LDR_START_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_PAD  = 2'd1,
        ST_KICK = 2'd2,
        ST_WAIT = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/fir_sample_loader.sv
// Streams a frame of samples into FIR sample memory (port A), zero-pads short frames,
// pulses fir_start and then holds off new input until the filter signals done.
module fir_sample_loader
    import fir_sample_loader_pkg::*;
#(
    parameter int DATA_W       = LDR_SAMPLE_W,
    parameter int ADDR_W       = LDR_ADDR_W,
    parameter int DEPTH        = LDR_DEPTH,
    parameter int START_CYCLES = LDR_START_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              fir_start,
    input  logic              fir_done,
    output logic              busy,
    output logic [ADDR_W:0]   frame_len
);

    localparam int                CNT_W     = $clog2(START_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(START_CYCLES - 1);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  start_cnt_q, start_cnt_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic              done_low_q, done_low_d;
    logic              accept_s;
    logic              at_last_s;

    assign s_ready   = (state_q == ST_LOAD);
    assign accept_s  = s_valid & s_ready;
    assign at_last_s = (wr_addr_q == LAST_ADDR);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign fir_start = start_q;
    assign frame_len = frame_len_q;
    assign busy      = (state_q != ST_LOAD);

    // Next-state and output decode for the load/pad/kick/wait sequence.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        start_d     = 1'b0;
        start_cnt_d = start_cnt_q;
        frame_len_d = frame_len_q;
        done_low_d  = done_low_q;

        case (state_q)
            ST_LOAD: begin
                done_low_d  = 1'b0;
                start_cnt_d = '0;
                if (accept_s) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_addr_q;
                    mem_data_d = s_data;
                    // A full frame ends on the last address regardless of s_last.
                    if (at_last_s) begin
                        state_d     = ST_KICK;
                        wr_addr_d   = '0;
                        frame_len_d = FULL_LEN;
                    end else if (s_last) begin
                        state_d     = ST_PAD;
                        wr_addr_d   = wr_addr_q + 1'b1;
                        frame_len_d = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            ST_PAD: begin
                mem_we_d   = 1'b1;
                mem_addr_d = wr_addr_q;
                mem_data_d = '0;
                if (at_last_s) begin
                    state_d   = ST_KICK;
                    wr_addr_d = '0;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            ST_KICK: begin
                start_d = 1'b1;
                if (!fir_done) begin
                    done_low_d = 1'b1;
                end else begin
                    done_low_d = done_low_q;
                end
                if (start_cnt_q == CNT_LAST) begin
                    state_d     = ST_WAIT;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // Only a rising done after a low phase releases the loader; a sticky high is ignored.
                if (done_low_q && fir_done) begin
                    state_d    = ST_LOAD;
                    done_low_d = 1'b0;
                end else if (!fir_done) begin
                    done_low_d = 1'b1;
                end else begin
                    done_low_d = done_low_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wr_addr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            start_q     <= 1'b0;
            start_cnt_q <= '0;
            frame_len_q <= '0;
            done_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            start_q     <= start_d;
            start_cnt_q <= start_cnt_d;
            frame_len_q <= frame_len_d;
            done_low_q  <= done_low_d;
        end
    end

endmodule
